combi_sweep_ctrl: RTL and testbench

- Self-checking sequencer for the 3-input combinational block Y = (A&B) | (!A&B) | (!B&C), which reduces to Y = B|C.
- On `start`, it drives every input combination onto the block in ascending binary order and holds each for a programmable number of cycles.
- It samples Y after each hold, compares it against a parameterised expected truth table, and reports the pass/fail result, the error count and the first failing index.
- It replaces hand-timed delay stimulus with a clocked, repeatable sweep usable in both simulation and hardware.

---
 rtl/combi_sweep_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_combi_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/combi_sweep_ctrl.sv
// combi_sweep_ctrl: clocked exhaustive sweep of a small combinational block.
// Drives every input vector in ascending order, holds each for HOLD_CYCLES,
// samples the block output, and compares it against the EXPECTED truth table.
// Results (pass, mismatch count, first failing index) persist until the next
// accepted start or reset.
module combi_sweep_ctrl #(
    parameter int                      N_IN        = 3,
    parameter int                      HOLD_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0]    EXPECTED    = 8'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_idx
);

    localparam int NV = 1 << N_IN;
    localparam int EW = N_IN + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [N_IN-1:0] LAST_IDX  = N_IN'(NV - 1);
    localparam logic [HW-1:0]   LAST_HOLD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [N_IN-1:0]   idx_r, idx_s;
    logic [HW-1:0]     hold_r, hold_s;
    logic [N_IN-1:0]   dut_in_r, dut_in_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              pass_r, pass_s;
    logic [N_IN:0]     err_count_r, err_count_s;
    logic              first_err_valid_r, first_err_valid_s;
    logic [N_IN-1:0]   first_err_idx_r, first_err_idx_s;
    logic              mismatch_s;
    logic [N_IN:0]     err_upd_s;

    // Compare the sampled block output with its expected truth-table bit.
    always_comb begin
        mismatch_s = (dut_y != EXPECTED[idx_r]);
        if (mismatch_s) begin
            err_upd_s = err_count_r + EW'(1'b1);
        end else begin
            err_upd_s = err_count_r;
        end
    end

    // Next-state logic; abort beats the final SAMPLE-to-DONE step.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = DRIVE;
                else       state_s = IDLE;
            end
            DRIVE: begin
                if (abort)                    state_s = IDLE;
                else if (hold_r == LAST_HOLD) state_s = SAMPLE;
                else                          state_s = DRIVE;
            end
            SAMPLE: begin
                if (abort)                  state_s = IDLE;
                else if (idx_r == LAST_IDX) state_s = DONE;
                else                        state_s = DRIVE;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the counters and registered outputs.
    always_comb begin
        idx_s             = idx_r;
        hold_s            = hold_r;
        dut_in_s          = dut_in_r;
        busy_s            = busy_r;
        done_s            = 1'b0;
        pass_s            = pass_r;
        err_count_s       = err_count_r;
        first_err_valid_s = first_err_valid_r;
        first_err_idx_s   = first_err_idx_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    idx_s             = '0;
                    hold_s            = '0;
                    dut_in_s          = '0;
                    busy_s            = 1'b1;
                    pass_s            = 1'b0;
                    err_count_s       = '0;
                    first_err_valid_s = 1'b0;
                    first_err_idx_s   = '0;
                end else begin
                    busy_s = 1'b0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    idx_s    = '0;
                    hold_s   = '0;
                    dut_in_s = '0;
                    busy_s   = 1'b0;
                    pass_s   = 1'b0;
                end else if (hold_r == LAST_HOLD) begin
                    hold_s = '0;
                end else begin
                    hold_s = hold_r + HW'(1'b1);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    // Partial error results are kept; the pending sample is dropped.
                    idx_s    = '0;
                    hold_s   = '0;
                    dut_in_s = '0;
                    busy_s   = 1'b0;
                    pass_s   = 1'b0;
                end else begin
                    err_count_s = err_upd_s;
                    if (mismatch_s && !first_err_valid_r) begin
                        first_err_valid_s = 1'b1;
                        first_err_idx_s   = idx_r;
                    end else begin
                        first_err_valid_s = first_err_valid_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        done_s = 1'b1;
                        pass_s = (err_upd_s == '0);
                    end else begin
                        idx_s    = idx_r + N_IN'(1'b1);
                        dut_in_s = idx_r + N_IN'(1'b1);
                        hold_s   = '0;
                    end
                end
            end
            DONE: begin
                // dut_in keeps the last vector; only idx wraps back.
                idx_s  = '0;
                busy_s = 1'b0;
            end
            default: begin
                idx_s  = '0;
                hold_s = '0;
                busy_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= IDLE;
            idx_r             <= '0;
            hold_r            <= '0;
            dut_in_r          <= '0;
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            pass_r            <= 1'b0;
            err_count_r       <= '0;
            first_err_valid_r <= 1'b0;
            first_err_idx_r   <= '0;
        end else begin
            state_r           <= state_s;
            idx_r             <= idx_s;
            hold_r            <= hold_s;
            dut_in_r          <= dut_in_s;
            busy_r            <= busy_s;
            done_r            <= done_s;
            pass_r            <= pass_s;
            err_count_r       <= err_count_s;
            first_err_valid_r <= first_err_valid_s;
            first_err_idx_r   <= first_err_idx_s;
        end
    end

    assign dut_in          = dut_in_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_count       = err_count_r;
    assign first_err_valid = first_err_valid_r;
    assign first_err_idx   = first_err_idx_r;

endmodule

// File: tb/tb_combi_sweep_ctrl.sv
// Directed bench for combi_sweep_ctrl: default instance (HOLD_CYCLES=2) driven
// by a selectable behavioural block model, plus a HOLD_CYCLES=1 instance for
// latency checks.
module tb_combi_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start, abort;
    logic [2:0] dut_in;
    logic       dut_y;
    logic       busy, done, pass, first_err_valid;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;

    logic       start1, abort1;
    logic [2:0] dut1_in;
    logic       dut1_y;
    logic       busy1, done1, pass1, first_err_valid1;
    logic [3:0] err_count1;
    logic [2:0] first_err_idx1;

    int mode;
    int checks;
    int errors;

    // 0: correct B|C, 1: stuck-at-0, 2: stuck-at-1, 3: faulty A&B
    function automatic logic model_y(input int m, input logic [2:0] v);
        case (m)
            0:       return v[1] | v[0];
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return v[2] & v[1];
            default: return 1'b0;
        endcase
    endfunction

    assign dut_y  = model_y(mode, dut_in);
    assign dut1_y = model_y(0, dut1_in);

    combi_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_in(dut_in), .dut_y(dut_y), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    combi_sweep_ctrl #(.N_IN(3), .HOLD_CYCLES(1), .EXPECTED(8'hEE)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .dut_in(dut1_in), .dut_y(dut1_y), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err_count1),
        .first_err_valid(first_err_valid1), .first_err_idx(first_err_idx1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a sweep on the default instance and wait for done (bounded).
    // n counts edges after the accepting edge; done is expected at n == 24.
    task automatic sweep(input int restart_at, output int n,
                         output bit seq_ok, output bit busy_ok);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        seq_ok = 1'b1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n < 24 && dut_in !== 3'(n / 3)) seq_ok = 1'b0;
            start = (n == restart_at);
            tick();
            n++;
        end
        start = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seq_ok, busy_ok, quiet;
        checks = 0;
        errors = 0;
        mode   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fev", first_err_valid, 0);
        check("rst_fei", first_err_idx, 0);
        check("rst_dut_in", dut_in, 0);
        check("rst_dut1", {busy1, done1, pass1, err_count1, dut1_in}, 0);

        // Correct model
        mode = 0;
        sweep(-1, n, seq_ok, busy_ok);
        check("ok_latency", n, 24);
        check("ok_seq", seq_ok, 1);
        check("ok_busy", busy_ok, 1);
        check("ok_pass", pass, 1);
        check("ok_err", err_count, 0);
        check("ok_fev", first_err_valid, 0);
        tick();
        check("ok_done_pulse", done, 0);
        check("ok_busy_after", busy, 0);
        check("ok_dut_in_hold", dut_in, 7);
        repeat (5) tick();
        check("ok_persist", {pass, err_count}, {1'b1, 4'd0});

        // Stuck-at-0
        mode = 1;
        sweep(-1, n, seq_ok, busy_ok);
        check("s0_latency", n, 24);
        check("s0_err", err_count, 6);
        check("s0_fev", first_err_valid, 1);
        check("s0_fei", first_err_idx, 1);
        check("s0_pass", pass, 0);
        tick();

        // Stuck-at-1
        mode = 2;
        sweep(-1, n, seq_ok, busy_ok);
        check("s1_err", err_count, 2);
        check("s1_fev", first_err_valid, 1);
        check("s1_fei", first_err_idx, 0);
        check("s1_pass", pass, 0);
        tick();

        // Faulty A&B
        mode = 3;
        sweep(-1, n, seq_ok, busy_ok);
        check("ab_err", err_count, 4);
        check("ab_fei", first_err_idx, 1);
        check("ab_pass", pass, 0);
        tick();

        // Start during busy is ignored
        mode = 2;
        sweep(4, n, seq_ok, busy_ok);
        check("rs_latency", n, 24);
        check("rs_busy", busy_ok, 1);
        check("rs_seq", seq_ok, 1);
        check("rs_err", err_count, 2);
        check("rs_fei", first_err_idx, 0);
        tick();

        // HOLD_CYCLES=1 instance latency
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("h1_latency", n, 16);
        check("h1_pass", pass1, 1);
        tick();

        // Abort in DRIVE of idx 4
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("ab4_dut_in", dut_in, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab4_busy", busy, 0);
        check("ab4_done", done, 0);
        check("ab4_dut_in0", dut_in, 0);
        check("ab4_pass", pass, 0);
        check("ab4_err", err_count, 3);
        check("ab4_fei", {first_err_valid, first_err_idx}, {1'b1, 3'd1});
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("ab4_quiet", quiet, 1);

        // Abort coinciding with final SAMPLE
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (23) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abf_done", done, 0);
        check("abf_busy", busy, 0);
        check("abf_pass", pass, 0);
        check("abf_dut_in", dut_in, 0);
        tick();
        check("abf_done2", done, 0);

        // Reset mid-sweep at idx 6
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (18) tick();
        check("rst6_dut_in", dut_in, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst6_outputs",
              {busy, done, pass, err_count, first_err_valid, first_err_idx, dut_in}, 0);

        // Restart after reset
        mode = 0;
        sweep(-1, n, seq_ok, busy_ok);
        check("rr_latency", n, 24);
        check("rr_seq", seq_ok, 1);
        check("rr_pass", pass, 1);
        check("rr_err", err_count, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
